// File: rtl/driver_displays_mux.sv
// driver_displays_mux
// Time-multiplexed seven-segment driver for N_DIGITOS hexadecimal digits.
// One shared hex decoder is fed by a scan counter. Common segment and anode
// buses drive the board pins. The displayed value is double-buffered: loads
// go to a shadow buffer, and the shadow is copied into the active buffer only
// at the end of a full scan frame, so a frame is never drawn half old and half
// new.
// Extras: leading-zero blanking, per-digit blink and a per-digit decimal point.
//
// Ports:
//   clk           system clock
//   reset         asynchronous, active-high reset
//   carregar      one-cycle strobe that captures valores_in / ponto_in
//   valores_in    hex nibbles; digit i = bits [4i+3:4i], digit 0 rightmost
//   ponto_in      decimal point request per digit, sampled with carregar
//   apagar_zeros  live enable for leading-zero blanking
//   pisca_mascara live mask of the digits that blink
//   seg_out       segments, bit0 = a .. bit6 = g
//   dp_out        decimal point
//   anodo_out     one-hot digit select
//   quadro_fim    one-cycle pulse after the end of each full scan frame
module driver_displays_mux #(
  parameter int unsigned N_DIGITOS       = 4,
  parameter int unsigned DIV_VARREDURA   = 50000,
  parameter int unsigned PISCA_QUADROS   = 25,
  parameter int unsigned SEG_ATIVO_BAIXO = 1,
  parameter int unsigned AN_ATIVO_BAIXO  = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   carregar,
  input  logic [4*N_DIGITOS-1:0] valores_in,
  input  logic [N_DIGITOS-1:0]   ponto_in,
  input  logic                   apagar_zeros,
  input  logic [N_DIGITOS-1:0]   pisca_mascara,
  output logic [6:0]             seg_out,
  output logic                   dp_out,
  output logic [N_DIGITOS-1:0]   anodo_out,
  output logic                   quadro_fim
);

  localparam int unsigned PRE_W = (DIV_VARREDURA > 1) ? $clog2(DIV_VARREDURA) : 1;
  localparam int unsigned IDX_W = (N_DIGITOS > 1) ? $clog2(N_DIGITOS) : 1;
  localparam int unsigned BLK_W = (PISCA_QUADROS > 1) ? $clog2(PISCA_QUADROS) : 1;

  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV_VARREDURA - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N_DIGITOS - 1);
  localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(PISCA_QUADROS - 1);

  localparam logic SEG_INV = (SEG_ATIVO_BAIXO != 0);
  localparam logic AN_INV  = (AN_ATIVO_BAIXO != 0);

  // Inactive pin levels for the chosen polarities.
  localparam logic [6:0]           SEG_OFF = {7{SEG_INV}};
  localparam logic                 DP_OFF  = SEG_INV;
  localparam logic [N_DIGITOS-1:0] AN_OFF  = {N_DIGITOS{AN_INV}};

  // Active-high segment pattern for one hex digit (bit0 = a .. bit6 = g).
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] p;
    unique case (v)
      4'h0: p = 7'h3F;
      4'h1: p = 7'h06;
      4'h2: p = 7'h5B;
      4'h3: p = 7'h4F;
      4'h4: p = 7'h66;
      4'h5: p = 7'h6D;
      4'h6: p = 7'h7D;
      4'h7: p = 7'h07;
      4'h8: p = 7'h7F;
      4'h9: p = 7'h6F;
      4'hA: p = 7'h77;
      4'hB: p = 7'h7C;
      4'hC: p = 7'h39;
      4'hD: p = 7'h5E;
      4'hE: p = 7'h79;
      4'hF: p = 7'h71;
    endcase
    return p;
  endfunction

  // State registers
  logic [PRE_W-1:0]       presc_q, presc_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [4*N_DIGITOS-1:0] shadow_val_q, shadow_val_d;
  logic [N_DIGITOS-1:0]   shadow_dp_q, shadow_dp_d;
  logic [4*N_DIGITOS-1:0] active_val_q, active_val_d;
  logic [N_DIGITOS-1:0]   active_dp_q, active_dp_d;
  logic [BLK_W-1:0]       blink_cnt_q, blink_cnt_d;
  logic                   blink_phase_q, blink_phase_d;

  // Registered outputs
  logic [6:0]           seg_q, seg_d;
  logic                 dp_q, dp_d;
  logic [N_DIGITOS-1:0] an_q, an_d;
  logic                 qf_q, qf_d;

  logic tick;
  logic frame_end;

  assign tick      = (presc_q == PRE_MAX);
  assign frame_end = tick && (idx_q == IDX_MAX);

  // Scan, buffering and blink timing
  always_comb begin
    presc_d       = presc_q + 1'b1;
    idx_d         = idx_q;
    shadow_val_d  = shadow_val_q;
    shadow_dp_d   = shadow_dp_q;
    active_val_d  = active_val_q;
    active_dp_d   = active_dp_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;

    if (tick) begin
      presc_d = '0;
      idx_d   = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    end

    if (carregar) begin
      shadow_val_d = valores_in;
      shadow_dp_d  = ponto_in;
    end

    if (frame_end) begin
      // A load in the frame-end cycle bypasses the shadow so it is not delayed
      // by a whole frame.
      active_val_d = carregar ? valores_in : shadow_val_q;
      active_dp_d  = carregar ? ponto_in : shadow_dp_q;
      if (blink_cnt_q == BLK_MAX) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  // Per-digit selection from the active buffer
  logic [N_DIGITOS-1:0] lead_zero;
  logic [N_DIGITOS-1:0] an_hot;
  logic [3:0]           digit_val;
  logic                 digit_dp;
  logic                 digit_blinks;
  logic                 digit_lz;

  always_comb begin
    lead_zero    = '0;
    an_hot       = '0;
    digit_val    = '0;
    digit_dp     = 1'b0;
    digit_blinks = 1'b0;
    digit_lz     = 1'b0;
    for (int i = 0; i < int'(N_DIGITOS); i++) begin
      // Digit i is a leading zero when it and every digit above it are zero.
      lead_zero[i] = ((active_val_q >> (4 * i)) == '0);
      if (idx_q == IDX_W'(i)) begin
        an_hot[i]    = 1'b1;
        digit_val    = active_val_q[4*i +: 4];
        digit_dp     = active_dp_q[i];
        digit_blinks = pisca_mascara[i];
        digit_lz     = lead_zero[i];
      end
    end
  end

  logic blank;
  logic blink_off;

  assign blank     = apagar_zeros && (idx_q != '0) && digit_lz;
  assign blink_off = blink_phase_q && digit_blinks;

  // Output stage. The cycle after a tick is a guard cycle with everything
  // dark so the old digit's segments never ghost onto the new anode.
  always_comb begin
    seg_d = SEG_OFF;
    dp_d  = DP_OFF;
    an_d  = AN_OFF;
    qf_d  = frame_end;
    if (!tick) begin
      an_d = an_hot ^ AN_OFF;
      if (!blank && !blink_off) begin
        seg_d = hex_to_seg(digit_val) ^ SEG_OFF;
        dp_d  = digit_dp ^ DP_OFF;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q       <= '0;
      idx_q         <= '0;
      shadow_val_q  <= '0;
      shadow_dp_q   <= '0;
      active_val_q  <= '0;
      active_dp_q   <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      seg_q         <= SEG_OFF;
      dp_q          <= DP_OFF;
      an_q          <= AN_OFF;
      qf_q          <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      idx_q         <= idx_d;
      shadow_val_q  <= shadow_val_d;
      shadow_dp_q   <= shadow_dp_d;
      active_val_q  <= active_val_d;
      active_dp_q   <= active_dp_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      an_q          <= an_d;
      qf_q          <= qf_d;
    end
  end

  assign seg_out    = seg_q;
  assign dp_out     = dp_q;
  assign anodo_out  = an_q;
  assign quadro_fim = qf_q;

endmodule

// File: doc/driver_displays_mux.md
Name: driver_displays_mux

Overview:
- Parametrised, time-multiplexed seven-segment driver for N hexadecimal digits.
- Replaces per-digit combinational decoders with one shared decoder, a scan counter and common segment/anode buses.
- Double-buffers the displayed value so updates never tear mid-frame.
- Adds leading-zero blanking, per-digit blink and decimal point; sits between datapath (score/state counters) and board display pins.

Parameters:
N_DIGITOS, 4, number of digits scanned (1..8)
DIV_VARREDURA, 50000, clock cycles each digit stays selected (>=2)
PISCA_QUADROS, 25, full scan frames per blink half-period (>=1)
SEG_ATIVO_BAIXO, 1, 1 = segment/dp pins active-low, 0 = active-high
AN_ATIVO_BAIXO, 1, 1 = digit-select pins active-low, 0 = active-high

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
carregar  in  1  one-cycle strobe: capture valores_in into shadow buffer
valores_in  in  4*N_DIGITOS  hex nibbles, digit i = bits [4i+3:4i], digit 0 rightmost
ponto_in  in  N_DIGITOS  decimal point request per digit, sampled with carregar
apagar_zeros  in  1  enable leading-zero blanking (live, not buffered)
pisca_mascara  in  N_DIGITOS  digits that blink (live, not buffered)
seg_out  out  7  segments, bit0=a .. bit6=g
dp_out  out  1  decimal point
anodo_out  out  N_DIGITOS  one-hot digit select
quadro_fim  out  1  one-cycle pulse at end of each full scan frame

Behaviour:
- Reset (async, active-high): prescaler=0, idx=0, shadow/active value and dp buffers=0, blink phase=0, blink frame count=0, quadro_fim=0; seg_out, dp_out and anodo_out all at their inactive level (e.g. seg=7'h7F, anodo=all 1s with both polarities low).
- Prescaler counts 0..DIV_VARREDURA-1. tick = (prescaler==DIV_VARREDURA-1). Prescaler wraps to 0 on tick.
- On tick: idx <= (idx==N_DIGITOS-1) ? 0 : idx+1.
- On tick with idx==N_DIGITOS-1 (frame end):
  - quadro_fim=1 in the following cycle, for exactly one cycle.
  - active <= pending, where pending = carregar ? valores_in/ponto_in : shadow. A carregar in the same cycle wins.
  - Blink frame count advances; at PISCA_QUADROS-1 it wraps to 0 and the blink phase toggles.
- carregar, any cycle: shadow <= valores_in, ponto_in. Has no visible effect before the next frame end.
- All outputs are registered with 1-cycle latency from idx/active.
- Guard cycle: in the cycle right after each tick, all anodes and segments are inactive (anti-ghosting). After that, digit idx is driven for DIV_VARREDURA-1 cycles.
- After reset release, digit 0 is driven from the first clock edge (no guard).
- Decode: full hex 0-F with standard patterns, for example 0=7'h3F, 4=7'h66, 5=7'h6D, A=7'h77, F=7'h71 (active-high form). Invert the pattern when SEG_ATIVO_BAIXO=1.
- Leading-zero blank: with apagar_zeros=1, digit i>0 is blank if active digits N-1..i are all 0. Digit 0 is never blanked by this rule. A blanked digit also suppresses dp.
- Blink: when blink phase=1 and pisca_mascara[idx]=1, segments and dp are inactive. The anode is still driven.
- anodo_out is one-hot for idx; invert the pattern when AN_ATIVO_BAIXO=1.
- N_DIGITOS=1: idx stays 0, every tick is a frame end.
- Reset mid-frame: immediate return to the reset state; shadow contents are lost.

Test Plan (N_DIGITOS=4, DIV_VARREDURA=4, PISCA_QUADROS=2, both polarities active-low):
1. Hold reset, then release -> during reset seg_out=7'h7F, dp_out=1, anodo_out=4'hF, quadro_fim=0. Cycle 1 after release: anodo_out=4'hE, seg_out=7'h40 (digit "0").
2. Free run, no loads -> anodo sequence E,F(guard),…; each digit active 3 cycles plus 1 guard. quadro_fim pulses every 16 cycles.
3. carregar with valores_in=16'h1234 mid-frame -> displayed digits stay 0 until the quadro_fim frame boundary. Next frame: digit0 seg_out=7'h19 ("4"), digit3 seg_out=7'h79 ("1").
4. Load 16'h0050 with apagar_zeros=1 -> digits 3 and 2 show seg_out=7'h7F, digit1=7'h12 ("5"), digit0=7'h40. Then load 16'h0000 -> only digit 0 lit.
5. carregar on the exact frame-end tick with 16'hABCD -> the new value appears in the immediately following frame. digit0=7'h21 ("d") in active-low form.
6. pisca_mascara=4'b0001, ponto_in=4'b0001 -> digit0 segments and dp lit for 2 frames, dark for 2 frames, repeating. Asserting reset mid-frame returns all outputs to the reset values within the same cycle.
